prog_clk_divider: RTL

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

---
 rtl/prog_clk_divider_pkg.sv | 7 +
 rtl/prog_clk_divider_ch.sv | 83 ++++++++
 rtl/prog_clk_divider.sv | 57 +++++
 3 files changed

// File: rtl/prog_clk_divider_pkg.sv
// Shared constants for the programmable clock divider.
package prog_clk_divider_pkg;

    localparam int unsigned DEF_DIV  = 25_000_000;
    localparam int unsigned CH_IDX_W = 4;

endpackage

// File: rtl/prog_clk_divider_ch.sv
// One divider channel: active/shadow period pair, counter and registered outputs.
module prog_clk_divider_ch #(
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned DEF_DIV = prog_clk_divider_pkg::DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_DIV / 2);

    logic [CNT_W-1:0] cnt, div_a, high_a, div_s, high_s;
    logic             pending, run_q;

    logic [CNT_W-1:0] cnt_nxt, div_a_nxt, high_a_nxt, div_s_nxt, high_s_nxt;
    logic             pending_nxt, period_start;

    // A period starts on the first enabled cycle or when the counter reaches its last step.
    always_comb begin
        period_start = en && (!run_q || (cnt >= div_a - CNT_W'(1)));
        cnt_nxt      = '0;
        div_a_nxt    = div_a;
        high_a_nxt   = high_a;
        div_s_nxt    = div_s;
        high_s_nxt   = high_s;
        pending_nxt  = pending;

        if (period_start && pending) begin
            div_a_nxt   = div_s;
            high_a_nxt  = high_s;
            pending_nxt = 1'b0;
        end

        if (en && !period_start) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        // New values land after the boundary swap, so a write coinciding with a wrap waits one period.
        if (wr) begin
            div_s_nxt  = wr_div;
            high_s_nxt = wr_high;
            if (en) begin
                pending_nxt = 1'b1;
            end else begin
                div_a_nxt   = wr_div;
                high_a_nxt  = wr_high;
                pending_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            div_a   <= RST_DIV;
            high_a  <= RST_HIGH;
            div_s   <= RST_DIV;
            high_s  <= RST_HIGH;
            pending <= 1'b0;
            run_q   <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_a   <= div_a_nxt;
            high_a  <= high_a_nxt;
            div_s   <= div_s_nxt;
            high_s  <= high_s_nxt;
            pending <= pending_nxt;
            run_q   <= en;
            clk_out <= en && (cnt_nxt < high_a_nxt);
            tick    <= period_start;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: write decode, ack/err and channel array.
module prog_clk_divider #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned DEF_DIV = prog_clk_divider_pkg::DEF_DIV
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CH-1:0]                       en,
    input  logic                                    wr_en,
    input  logic [prog_clk_divider_pkg::CH_IDX_W-1:0] wr_ch,
    input  logic [CNT_W-1:0]                        wr_div,
    input  logic [CNT_W-1:0]                        wr_high,
    output logic                                    wr_ack,
    output logic                                    wr_err,
    output logic [NUM_CH-1:0]                       clk_out,
    output logic [NUM_CH-1:0]                       tick
);

    import prog_clk_divider_pkg::*;

    logic              wr_ok_c;
    logic [NUM_CH-1:0] ch_wr_c;

    always_comb begin
        wr_ok_c = (32'(wr_ch) < NUM_CH) && (wr_div >= CNT_W'(2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_en && wr_ok_c;
            wr_err <= wr_en && !wr_ok_c;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr_c[i] = wr_en && wr_ok_c && (wr_ch == CH_IDX_W'(i));

        prog_clk_divider_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (en[i]),
            .wr      (ch_wr_c[i]),
            .wr_div  (wr_div),
            .wr_high (wr_high),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
